// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB pipeline register with load alignment and writeback select (optional RETIRE_CNT_EN adds instret)
module wb_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            valid_m,
  input  logic            RegWrite_m,
  input  logic [4:0]      rd_m,
  input  logic [1:0]      ResultSrc_m,
  input  logic [2:0]      funct3_m,
  input  logic [XLEN-1:0] ALUResult_m,
  input  logic [XLEN-1:0] ReadData_m,
  input  logic [XLEN-1:0] PCPlus4_m,
`ifdef RETIRE_CNT_EN
  output logic [63:0]     instret,
`endif
  output logic            RegWrite,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] WD3,
  output logic            valid_w
);

  logic            valid_q;
  logic            reg_write_q;
  logic [4:0]      rd_q;
  logic [1:0]      result_src_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] alu_result_q;
  logic [XLEN-1:0] read_data_q;
  logic [XLEN-1:0] pc_plus4_q;

  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic [XLEN-1:0] load_value;

  // Pipeline register: reset beats flush beats stall beats capture
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      result_src_q <= '0;
      funct3_q     <= '0;
      alu_result_q <= '0;
      read_data_q  <= '0;
      pc_plus4_q   <= '0;
    end else if (!stall) begin
      valid_q      <= valid_m;
      reg_write_q  <= RegWrite_m & valid_m;
      rd_q         <= rd_m;
      result_src_q <= ResultSrc_m;
      funct3_q     <= funct3_m;
      alu_result_q <= ALUResult_m;
      read_data_q  <= ReadData_m;
      pc_plus4_q   <= PCPlus4_m;
    end
  end

  // Pick the addressed byte and halfword out of the little-endian memory word
  always_comb begin
    load_byte = 8'h00;
    case (alu_result_q[1:0])
      2'd0: load_byte = read_data_q[7:0];
      2'd1: load_byte = read_data_q[15:8];
      2'd2: load_byte = read_data_q[23:16];
      2'd3: load_byte = read_data_q[31:24];
      default: load_byte = 8'h00;
    endcase
    load_half = alu_result_q[1] ? read_data_q[31:16] : read_data_q[15:0];
  end

  // Sign- or zero-extend by funct3; LW and unused encodings pass the whole word
  always_comb begin
    load_value = read_data_q;
    case (funct3_q)
      3'b000: load_value = {{24{load_byte[7]}}, load_byte};
      3'b100: load_value = {24'h000000, load_byte};
      3'b001: load_value = {{16{load_half[15]}}, load_half};
      3'b101: load_value = {16'h0000, load_half};
      default: load_value = read_data_q;
    endcase
  end

  // Writeback result mux; the reserved select yields zero
  always_comb begin
    WD3 = '0;
    case (result_src_q)
      2'b00: WD3 = alu_result_q;
      2'b01: WD3 = load_value;
      2'b10: WD3 = pc_plus4_q;
      default: WD3 = '0;
    endcase
  end

  // Write port status; x0 writes are dropped but rd still shows the address
  always_comb begin
    RegWrite = reg_write_q & valid_q & (rd_q != 5'd0);
    rd       = rd_q;
    valid_w  = valid_q;
  end

`ifdef RETIRE_CNT_EN
  // Count instructions leaving WB; a flush only kills the incoming slot
  always_ff @(posedge clk) begin
    if (rst) begin
      instret <= '0;
    end else if (valid_q && !stall) begin
      instret <= instret + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed self-checking bench for wb_stage
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, valid_m, RegWrite_m;
  logic [4:0]  rd_m;
  logic [1:0]  ResultSrc_m;
  logic [2:0]  funct3_m;
  logic [31:0] ALUResult_m, ReadData_m, PCPlus4_m;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [31:0] WD3;
  logic        valid_w;
`ifdef RETIRE_CNT_EN
  logic [63:0] instret;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .valid_m(valid_m), .RegWrite_m(RegWrite_m), .rd_m(rd_m),
    .ResultSrc_m(ResultSrc_m), .funct3_m(funct3_m),
    .ALUResult_m(ALUResult_m), .ReadData_m(ReadData_m), .PCPlus4_m(PCPlus4_m),
`ifdef RETIRE_CNT_EN
    .instret(instret),
`endif
    .RegWrite(RegWrite), .rd(rd), .WD3(WD3), .valid_w(valid_w)
  );

  task automatic drive(input logic v, input logic we, input logic [4:0] r,
                       input logic [1:0] src, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [31:0] pc4);
    valid_m = v; RegWrite_m = we; rd_m = r; ResultSrc_m = src;
    funct3_m = f3; ALUResult_m = alu; ReadData_m = rdata; PCPlus4_m = pc4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 1'b1, 5'd7, 2'b10, 3'b010, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0040);
    tick();
    tick();
    vec_cnt++;
    if (RegWrite !== 1'b0 || rd !== 5'd0 || WD3 !== 32'h0 || valid_w !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset: RegWrite=%b rd=%0d WD3=%h valid_w=%b, want 0/0/0/0", RegWrite, rd, WD3, valid_w);
    end
`ifdef RETIRE_CNT_EN
    vec_cnt++;
    if (instret !== 64'd0) begin
      err_cnt++;
      $display("FAIL reset_instret: got %0d want 0", instret);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_alu();
    drive(1'b1, 1'b1, 5'd5, 2'b00, 3'b000, 32'h0000_1234, 32'h0, 32'h0);
    tick();
    vec_cnt++;
    if (RegWrite !== 1'b1 || rd !== 5'd5 || WD3 !== 32'h0000_1234 || valid_w !== 1'b1) begin
      err_cnt++;
      $display("FAIL alu_wb: RegWrite=%b rd=%0d WD3=%h valid_w=%b, want 1/5/00001234/1", RegWrite, rd, WD3, valid_w);
    end
    drive(1'b1, 1'b1, 5'd0, 2'b00, 3'b000, 32'h0000_1234, 32'h0, 32'h0);
    tick();
    vec_cnt++;
    if (RegWrite !== 1'b0 || rd !== 5'd0 || WD3 !== 32'h0000_1234) begin
      err_cnt++;
      $display("FAIL alu_x0: RegWrite=%b rd=%0d WD3=%h, want 0/0/00001234", RegWrite, rd, WD3);
    end
    drive(1'b0, 1'b1, 5'd6, 2'b00, 3'b000, 32'h0000_0055, 32'h0, 32'h0);
    tick();
    vec_cnt++;
    if (RegWrite !== 1'b0 || valid_w !== 1'b0) begin
      err_cnt++;
      $display("FAIL invalid_slot: RegWrite=%b valid_w=%b, want 0/0", RegWrite, valid_w);
    end
    drive(1'b1, 1'b1, 5'd6, 2'b11, 3'b000, 32'h0000_0055, 32'hFFFF_FFFF, 32'h0000_0100);
    tick();
    vec_cnt++;
    if (WD3 !== 32'h0) begin
      err_cnt++;
      $display("FAIL reserved_src: WD3=%h want 00000000", WD3);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3_t  [7] = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b101, 3'b010, 3'b100};
    logic [31:0] adr_t [7] = '{32'h1000, 32'h1000, 32'h1001, 32'h1002, 32'h1002, 32'h1003, 32'h1003};
    logic [31:0] exp_t [7] = '{32'hFFFF_FF81, 32'h0000_0081, 32'h0000_007F, 32'hFFFF_80F0,
                               32'h0000_80F0, 32'h80F0_7F81, 32'h0000_0080};
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, 5'd10, 2'b01, f3_t[i], adr_t[i], 32'h80F0_7F81, 32'h0);
      tick();
      vec_cnt++;
      if (WD3 !== exp_t[i] || RegWrite !== 1'b1 || rd !== 5'd10) begin
        err_cnt++;
        $display("FAIL load[%0d]: WD3=%h RegWrite=%b rd=%0d, want %h/1/10", i, WD3, RegWrite, rd, exp_t[i]);
      end
    end
  endtask

  task automatic test_jal();
    drive(1'b1, 1'b1, 5'd1, 2'b10, 3'b000, 32'h0000_0200, 32'h0, 32'h0000_0104);
    tick();
    vec_cnt++;
    if (WD3 !== 32'h0000_0104 || rd !== 5'd1 || RegWrite !== 1'b1) begin
      err_cnt++;
      $display("FAIL jal_link: WD3=%h rd=%0d RegWrite=%b, want 00000104/1/1", WD3, rd, RegWrite);
    end
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 1'b1, 5'd3, 2'b00, 3'b000, 32'h0000_AAAA, 32'h0, 32'h0);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 5'd9 + 5'(i), 2'b10, 3'b000, 32'h5555_0000, 32'h0, 32'h0000_0300);
      tick();
      vec_cnt++;
      if (rd !== 5'd3 || WD3 !== 32'h0000_AAAA || RegWrite !== 1'b1 || valid_w !== 1'b1) begin
        err_cnt++;
        $display("FAIL stall_hold[%0d]: rd=%0d WD3=%h RegWrite=%b valid_w=%b, want 3/0000aaaa/1/1", i, rd, WD3, RegWrite, valid_w);
      end
    end
    flush = 1'b1;
    tick();
    vec_cnt++;
    if (valid_w !== 1'b0 || RegWrite !== 1'b0 || rd !== 5'd0 || WD3 !== 32'h0) begin
      err_cnt++;
      $display("FAIL flush_stall: valid_w=%b RegWrite=%b rd=%0d WD3=%h, want 0/0/0/0", valid_w, RegWrite, rd, WD3);
    end
    flush = 1'b0;
    stall = 1'b0;
    drive(1'b1, 1'b1, 5'd4, 2'b00, 3'b000, 32'h0000_0444, 32'h0, 32'h0);
    tick();
    stall = 1'b1;
    rst = 1'b1;
    tick();
    vec_cnt++;
    if (valid_w !== 1'b0 || RegWrite !== 1'b0 || rd !== 5'd0 || WD3 !== 32'h0) begin
      err_cnt++;
      $display("FAIL reset_in_stall: valid_w=%b RegWrite=%b rd=%0d WD3=%h, want 0/0/0/0", valid_w, RegWrite, rd, WD3);
    end
    rst = 1'b0;
    stall = 1'b0;
  endtask

`ifdef RETIRE_CNT_EN
  task automatic test_counter();
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b1, 5'd1, 2'b00, 3'b000, 32'h1, 32'h0, 32'h0);
    tick();
    drive(1'b1, 1'b1, 5'd2, 2'b00, 3'b000, 32'h2, 32'h0, 32'h0);
    tick();
    stall = 1'b1;
    tick();
    tick();
    vec_cnt++;
    if (instret !== 64'd1) begin
      err_cnt++;
      $display("FAIL instret_stalled: got %0d want 1", instret);
    end
    stall = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b1, 1'b1, 5'd3, 2'b00, 3'b000, 32'h3, 32'h0, 32'h0);
    tick();
    drive(1'b1, 1'b1, 5'd4, 2'b00, 3'b000, 32'h4, 32'h0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
    tick();
    tick();
    tick();
    vec_cnt++;
    if (instret !== 64'd4) begin
      err_cnt++;
      $display("FAIL instret_drain: got %0d want 4", instret);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_jal();
    test_stall_flush();
`ifdef RETIRE_CNT_EN
    test_counter();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register and writeback-result formation for the RV32I core.
- Captures the memory-stage instruction and aligns and extends load data.
- Selects the writeback result and drives the register file write port (RegWrite, rd, WD3).
- Provides a one-cycle-latency result path and hazard-visible status (rd, RegWrite) for forwarding logic.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- stall  in  1  hold the WB register contents
- flush  in  1  replace the incoming instruction with a bubble
- valid_m  in  1  MEM-stage slot holds a real instruction
- RegWrite_m  in  1  instruction writes rd
- rd_m  in  5  destination register address
- ResultSrc_m  in  2  00 ALU, 01 load, 10 PC+4, 11 reserved
- funct3_m  in  3  load width/sign (RV32I encoding)
- ALUResult_m  in  32  ALU result / load byte address
- ReadData_m  in  32  raw word from data memory (little-endian)
- PCPlus4_m  in  32  PC+4 of the instruction
- RegWrite  out  1  register-file write enable
- rd  out  5  register-file write address
- WD3  out  32  register-file write data
- valid_w  out  1  WB slot holds a real instruction

Behaviour:
- Clocking: one clock, clk. rst is synchronous and active-high.
- Registered fields: valid, RegWrite, rd, ResultSrc, funct3, ALUResult, ReadData, PCPlus4.
- Priority at each posedge clk: rst > flush > stall > capture.
- rst: all registered fields cleared to 0, so RegWrite=0, rd=0, WD3=0, valid_w=0. Reset mid-stall or mid-flush wins unconditionally.
- flush: valid=0, RegWrite=0, other fields cleared. flush with stall=1 still flushes.
- stall (no flush): all fields hold. Outputs stay constant. A held RegWrite rewrites the same value each cycle, which is harmless.
- Otherwise: all *_m inputs are captured. If valid_m=0, RegWrite is captured as 0.
- Latency: inputs are visible at the outputs 1 cycle after capture. The register file commits on the following edge.
- RegWrite output = RegWrite_q & valid_q & (rd_q != 0). Writes to x0 are suppressed; rd still reflects rd_q.
- WD3, combinational from registered fields:
  - ResultSrc 00 -> ALUResult_q
  - ResultSrc 01 -> aligned load value
  - ResultSrc 10 -> PCPlus4_q
  - ResultSrc 11 -> 0
- Load alignment uses off = ALUResult_q[1:0]:
  - funct3 000 LB: byte at ReadData_q[8*off+7:8*off], sign-extended
  - 100 LBU: same byte, zero-extended
  - 001 LH: halfword at ReadData_q[16*off[1]+15:16*off[1]], sign-extended; off[0] ignored
  - 101 LHU: same halfword, zero-extended
  - 010 LW and all other encodings: full ReadData_q; off ignored
- valid_w = valid_q.
- No internal state beyond the pipeline register, plus the counter under the optional feature.

Optional Feature:
- Macro: RETIRE_CNT_EN.
- Defined:
  - Adds output port instret [63:0].
  - Cleared by rst.
  - Increments by 1 at each posedge where rst=0, valid_q=1 and stall=0, i.e. the WB instruction leaves the stage. flush does not suppress the increment, because flush kills only the incoming instruction.
  - Wraps from 2^64-1 to 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: rst=1 for 2 cycles with arbitrary inputs -> RegWrite=0, rd=0, WD3=0, valid_w=0 (instret=0 if enabled).
- ALU writeback: valid_m=1, RegWrite_m=1, rd_m=5, ResultSrc_m=00, ALUResult_m=0x0000_1234 -> next cycle RegWrite=1, rd=5, WD3=0x0000_1234. Same with rd_m=0 -> RegWrite=0.
- Loads with ReadData_m=0x80F0_7F81, ResultSrc_m=01:
  - LB, addr ...0 -> 0xFFFF_FF81
  - LBU, addr ...0 -> 0x0000_0081
  - LB, addr ...1 -> 0x0000_007F
  - LH, addr ...2 -> 0xFFFF_80F0
  - LHU, addr ...2 -> 0x0000_80F0
  - LW -> 0x80F0_7F81
- JAL link: ResultSrc_m=10, PCPlus4_m=0x0000_0104, rd_m=1 -> WD3=0x0000_0104, rd=1, RegWrite=1.
- Stall/flush: capture instr A (rd=3), then stall=1 for 3 cycles with new inputs -> outputs hold A. Then flush=1 and stall=1 together -> next cycle valid_w=0, RegWrite=0.
- Counter (RETIRE_CNT_EN): 4 valid instructions with one 2-cycle stall and one flush bubble inserted -> instret=4 after drain. Stalled cycles and the bubble do not count.
